alu_issue_ctrl: RTL and testbench

Sequential initiator that sits between the datapath control and the 32-bit combinational gate-level ALU. It accepts one operation request at a time over a valid/ready handshake and decodes the function code into the 3-bit ALU op. It drives the ALU's operands and op, then waits a fixed settle window for the gate delays to resolve. It captures the result and flags, computes signed overflow and the SLT result locally, and returns a response over a second valid/ready handshake.

---
 rtl/alu_issue_ctrl.sv | 154 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: valid/ready sequencer that issues one op to a combinational ALU, waits a settle window, captures result and flags
module alu_issue_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int WIDTH         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_set,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_cout,
    output logic             resp_zero,
    output logic             resp_ovf,
    output logic             resp_err
);
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]       op_q, op_d;
    logic             cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;
    logic             legal;
    logic [2:0]       op_dec;
    logic             a31, b31, r31, ovf_add, ovf_sub, ovf_slt, is_arith;
    logic [WIDTH-1:0] cap_res;

    // Decode the function code into the ALU op and flag unsupported codes
    always_comb begin
        legal  = 1'b1;
        op_dec = OP_AND;
        case (req_funct)
            4'd0:    op_dec = OP_AND;
            4'd1:    op_dec = OP_OR;
            4'd2:    op_dec = OP_ADD;
            4'd6:    op_dec = OP_SUB;
            4'd7:    op_dec = OP_SLT;
            default: legal  = 1'b0;
        endcase
    end

    // Capture-side flags; SLT's result bus carries only the set bit, so its sign comes from alu_set
    always_comb begin
        a31      = a_q[WIDTH-1];
        b31      = b_q[WIDTH-1];
        r31      = alu_result[WIDTH-1];
        ovf_add  = (a31 == b31) & (r31 != a31);
        ovf_sub  = (a31 != b31) & (r31 != a31);
        ovf_slt  = (a31 != b31) & (alu_set != a31);
        is_arith = (op_q == OP_ADD) | (op_q == OP_SUB);
        cap_res  = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, alu_set ^ ovf_slt} : alu_result;
    end

    // Next-state logic: accept in IDLE, count down the settle window in ISSUE, hold in RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid && legal) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = op_dec;
                    cnt_d   = 4'(SETTLE_CYCLES - 1);
                    state_d = ISSUE;
                end else if (req_valid) begin
                    res_d   = '0;
                    zero_d  = 1'b1;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            ISSUE: begin
                if (cnt_q == 4'd0) begin
                    res_d   = cap_res;
                    zero_d  = ~|cap_res;
                    cout_d  = is_arith & alu_cout;
                    ovf_d   = is_arith & (op_q[2] ? ovf_sub : ovf_add);
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            res_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign resp_result = res_q;
    assign resp_cout   = cout_q;
    assign resp_zero   = zero_q;
    assign resp_ovf    = ovf_q;
    assign resp_err    = err_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and random checks of alu_issue_ctrl against an arithmetic reference model
module tb_alu_issue_ctrl;
    localparam int S = 4;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, resp_valid, resp_ready;
    logic [3:0]  req_funct;
    logic [31:0] req_a, req_b, alu_a, alu_b, alu_result, resp_result;
    logic [2:0]  alu_op;
    logic        alu_cout, alu_set, resp_cout, resp_zero, resp_ovf, resp_err;
    logic [32:0] alu_sum;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] last_a = '0, last_b = '0;
    logic [2:0]  last_op = '0;
    logic [31:0] e_r;
    logic        e_c, e_v, e_e;
    logic [2:0]  e_op;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.SETTLE_CYCLES(S), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_set(alu_set),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_cout(resp_cout), .resp_zero(resp_zero),
        .resp_ovf(resp_ovf), .resp_err(resp_err)
    );

    // Stand-in combinational ALU: adder always active, cout/set driven for every op
    assign alu_sum    = {1'b0, alu_a} + {1'b0, alu_op[2] ? ~alu_b : alu_b} + 33'(alu_op[2]);
    assign alu_result = alu_op[1:0] == 2'b00 ? (alu_a & alu_b) :
                        alu_op[1:0] == 2'b01 ? (alu_a | alu_b) :
                        alu_op[1:0] == 2'b10 ? alu_sum[31:0] : {31'b0, alu_sum[31]};
    assign alu_cout   = alu_sum[32];
    assign alu_set    = alu_sum[31];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e_r = '0; e_c = 1'b0; e_v = 1'b0; e_e = 1'b0; e_op = last_op;
        case (f)
            4'd0: begin e_op = 3'b000; e_r = a & b; end
            4'd1: begin e_op = 3'b001; e_r = a | b; end
            4'd2: begin
                e_op = 3'b010; e_r = a + b;
                e_c = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
                s = sa + sb; e_v = (s > MAXS) || (s < MINS);
            end
            4'd6: begin
                e_op = 3'b110; e_r = a - b;
                e_c = (a >= b);
                s = sa - sb; e_v = (s > MAXS) || (s < MINS);
            end
            4'd7: begin e_op = 3'b111; e_r = {31'b0, sa < sb}; end
            default: e_e = 1'b1;
        endcase
    endtask

    task automatic accept(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        model(f, a, b);
        chk("req_ready_before", 64'(req_ready), 64'(1));
        req_valid = 1'b1; req_funct = f; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_funct = 4'($urandom);
        chk("alu_op", 64'(alu_op), 64'(e_op));
        chk("alu_a", 64'(alu_a), 64'(e_e ? last_a : a));
        chk("alu_b", 64'(alu_b), 64'(e_e ? last_b : b));
        if (!e_e) begin last_a = a; last_b = b; last_op = e_op; end
    endtask

    task automatic wait_and_check(input string tag);
        int k = 0;
        while (!resp_valid && k < 40) begin
            @(posedge clk); #1; k++;
            chk({tag, "_alu_a_held"}, 64'(alu_a), 64'(last_a));
        end
        chk({tag, "_latency"}, 64'(k), 64'(e_e ? 0 : S));
        chk({tag, "_result"}, 64'(resp_result), 64'(e_r));
        chk({tag, "_cout"}, 64'(resp_cout), 64'(e_c));
        chk({tag, "_ovf"}, 64'(resp_ovf), 64'(e_v));
        chk({tag, "_zero"}, 64'(resp_zero), 64'(e_r == 0));
        chk({tag, "_err"}, 64'(resp_err), 64'(e_e));
        chk({tag, "_req_ready_busy"}, 64'(req_ready), 64'(0));
    endtask

    task automatic handshake(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 64'(resp_valid), 64'(1));
            chk({tag, "_hold_result"}, 64'(resp_result), 64'(e_r));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, "_resp_valid_drop"}, 64'(resp_valid), 64'(0));
        chk({tag, "_req_ready_back"}, 64'(req_ready), 64'(1));
        chk({tag, "_result_kept"}, 64'(resp_result), 64'(e_r));
    endtask

    task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        accept(f, a, b);
        wait_and_check(tag);
        handshake(tag, int'($urandom_range(0, 2)));
    endtask

    logic [3:0]  ftab [8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd2, 4'd6, 4'd7};
    logic [31:0] ctab [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};

    initial begin
        logic [3:0]  f;
        logic [31:0] a, b, hold_a;
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_funct = '0; req_a = '0; req_b = '0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_zero", 64'(resp_zero), 64'(0));
        chk("rst_alu_op", 64'(alu_op), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset pulse with an ADD in flight
        accept(4'd2, 32'h1234_5678, 32'h1111_1111);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_alu_a", 64'(alu_a), 64'(0));
        chk("midrst_alu_b", 64'(alu_b), 64'(0));
        chk("midrst_alu_op", 64'(alu_op), 64'(0));
        chk("midrst_resp_valid", 64'(resp_valid), 64'(0));
        chk("midrst_req_ready", 64'(req_ready), 64'(1));
        chk("midrst_resp_result", 64'(resp_result), 64'(0));
        chk("midrst_flags", 64'({resp_cout, resp_zero, resp_ovf, resp_err}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_a = '0; last_b = '0; last_op = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("postrst_no_resp", 64'(resp_valid), 64'(0));
            chk("postrst_req_ready", 64'(req_ready), 64'(1));
        end

        // Directed operations
        run_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
        run_op("sub_eq", 4'd6, 32'd5, 32'd5);
        run_op("and", 4'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        run_op("or", 4'd1, 32'hF0F0_0000, 32'h0000_0F0F);
        run_op("slt_neg", 4'd7, 32'hFFFF_FFFF, 32'd1);
        run_op("slt_ovf", 4'd7, 32'h8000_0000, 32'd1);
        run_op("slt_rev", 4'd7, 32'd1, 32'h8000_0000);
        run_op("slt_ge", 4'd7, 32'd3, 32'd2);
        run_op("illegal3", 4'h3, 32'hDEAD_BEEF, 32'h1);
        run_op("sub_ovf", 4'd6, 32'h8000_0000, 32'd1);
        run_op("illegalF", 4'hF, 32'h0, 32'h0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            f = ftab[$urandom_range(0, 7)];
            if ($urandom_range(0, 5) == 0) f = 4'($urandom);
            a = ($urandom_range(0, 3) == 0) ? ctab[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? ctab[$urandom_range(0, 5)] : $urandom;
            run_op("rand", f, a, b);
        end

        // Back-pressure with a pending request and changing operands
        accept(4'd6, 32'h0000_0010, 32'h0000_0020);
        wait_and_check("bp");
        req_valid = 1'b1; req_funct = 4'd2; req_b = 32'h0000_0003;
        for (int i = 0; i < 5; i++) begin
            req_a = $urandom;
            @(posedge clk); #1;
            chk("bp_valid", 64'(resp_valid), 64'(1));
            chk("bp_result", 64'(resp_result), 64'(e_r));
            chk("bp_flags", 64'({resp_cout, resp_ovf, resp_zero, resp_err}), 64'({e_c, e_v, e_r == 0, e_e}));
            chk("bp_req_ready", 64'(req_ready), 64'(0));
            chk("bp_alu_a", 64'(alu_a), 64'(32'h0000_0010));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("bp_drop", 64'(resp_valid), 64'(0));
        chk("bp_req_ready_back", 64'(req_ready), 64'(1));
        hold_a = req_a;
        model(4'd2, hold_a, 32'h0000_0003);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_pending_accept", 64'(req_ready), 64'(0));
        chk("bp_pending_alu_a", 64'(alu_a), 64'(hold_a));
        chk("bp_pending_op", 64'(alu_op), 64'(3'b010));
        last_a = hold_a; last_b = 32'h0000_0003; last_op = 3'b010;
        wait_and_check("bp_pending");
        handshake("bp_pending", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
